// File: rtl/brimm_enc.sv
// brimm_enc: packs offset/reg fields into RV32 BRANCH/JAL/JALR words.
// Optional ENC_STATS_EN builds saturating encode/error counters.
module brimm_enc #(
  parameter int OUT_DEPTH = 4,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_kind,
  input  logic [31:0]      in_offset,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [2:0]       in_funct3,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_inst,
  output logic             out_err,
  output logic [CNT_W-1:0] enc_count,
  output logic [CNT_W-1:0] err_count
);

  localparam int PW = $clog2(OUT_DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(OUT_DEPTH);
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic          s1_valid;
  logic [1:0]    s1_kind;
  logic [31:0]   s1_off;
  logic [4:0]    s1_rd;
  logic [4:0]    s1_rs1;
  logic [4:0]    s1_rs2;
  logic [2:0]    s1_f3;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   fifo_cnt;
  logic [32:0]   mem [OUT_DEPTH];
  logic [32:0]   head;

  logic          pop;
  logic          push;
  logic          s1_adv;
  logic          accept;
  logic [31:0]   enc_inst;
  logic          enc_err;

  assign out_valid = (fifo_cnt != '0);
  assign pop       = out_valid && out_ready;
  assign s1_adv    = s1_valid && ((fifo_cnt < DEPTH_C) || pop);
  assign push      = s1_adv && !flush;
  assign in_ready  = !flush && (!s1_valid || s1_adv);
  assign accept    = in_valid && in_ready;

  assign head     = mem[rd_ptr];
  assign out_inst = out_valid ? head[31:0] : '0;
  assign out_err  = out_valid && head[32];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_kind  <= '0;
      s1_off   <= '0;
      s1_rd    <= '0;
      s1_rs1   <= '0;
      s1_rs2   <= '0;
      s1_f3    <= '0;
    end else if (flush) begin
      s1_valid <= 1'b0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_kind  <= in_kind;
      s1_off   <= in_offset;
      s1_rd    <= in_rd;
      s1_rs1   <= in_rs1;
      s1_rs2   <= in_rs2;
      s1_f3    <= in_funct3;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  // Illegal kinds and out-of-range/odd offsets collapse to a flagged NOP
  always_comb begin
    enc_inst = NOP;
    enc_err  = 1'b1;
    unique case (s1_kind)
      2'd0: if (s1_off[31:12] == {20{s1_off[12]}} && !s1_off[0]) begin
        enc_inst = {s1_off[12], s1_off[10:5], s1_rs2, s1_rs1,
                    s1_f3, s1_off[4:1], s1_off[11], 7'b1100011};
        enc_err  = 1'b0;
      end
      2'd1: if (s1_off[31:20] == {12{s1_off[20]}} && !s1_off[0]) begin
        enc_inst = {s1_off[20], s1_off[10:1], s1_off[11],
                    s1_off[19:12], s1_rd, 7'b1101111};
        enc_err  = 1'b0;
      end
      2'd2: if (s1_off[31:11] == {21{s1_off[11]}} && !s1_off[0]) begin
        enc_inst = {s1_off[11:0], s1_rs1, 3'b000, s1_rd, 7'b1100111};
        enc_err  = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      fifo_cnt <= fifo_cnt + 1'b1;
      else if (!push && pop) fifo_cnt <= fifo_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {enc_err, enc_inst};
  end

`ifdef ENC_STATS_EN
  logic [CNT_W-1:0] enc_q;
  logic [CNT_W-1:0] err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enc_q <= '0;
      err_q <= '0;
    end else if (push) begin
      if (enc_err) begin
        if (err_q != '1) err_q <= err_q + 1'b1;
      end else if (enc_q != '1) begin
        enc_q <= enc_q + 1'b1;
      end
    end
  end

  assign enc_count = enc_q;
  assign err_count = err_q;
`else
  assign enc_count = '0;
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_brimm_enc.sv
// tb_brimm_enc: directed checks of encoding, FIFO flow, flush and reset.
// Define ENC_STATS_EN to also exercise the saturating counters.
module tb_brimm_enc;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_kind;
  logic [31:0] in_offset;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [2:0]  in_funct3;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic        out_err;
  logic [15:0] enc_count;
  logic [15:0] err_count;

  int errors = 0;
  int checks = 0;
  int next_id;
  int pop_id;

`ifdef ENC_STATS_EN
  localparam int EXP_OK  = 4;
  localparam int EXP_BAD = 4;
`else
  localparam int EXP_OK  = 0;
  localparam int EXP_BAD = 0;
`endif

  always #5 clk = ~clk;

  brimm_enc #(.OUT_DEPTH(4), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_kind(in_kind), .in_offset(in_offset),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_err(out_err),
    .enc_count(enc_count), .err_count(err_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [1:0] k, input logic [31:0] o,
                          input logic [4:0] rd, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic [2:0] f3);
    in_kind = k; in_offset = o; in_rd = rd;
    in_rs1 = rs1; in_rs2 = rs2; in_funct3 = f3;
    in_valid = 1'b1;
    #1;
    chk("accept_ready", {31'b0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic head(input string tag, input logic [31:0] inst,
                      input logic err);
    chk({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
    chk({tag, "_inst"}, out_inst, inst);
    chk({tag, "_err"}, {31'b0, out_err}, {31'b0, err});
  endtask

  // Streams JAL offset 8 with rd=id: inst = 0x0080006F | id<<7
  task automatic cyc(input bit iv, input bit ordy, input bit must_pop);
    logic rdy;
    logic pv;
    in_valid = iv; in_kind = 2'd1; in_offset = 32'd8;
    in_rd = next_id[4:0]; out_ready = ordy;
    #1;
    rdy = in_ready;
    pv  = out_valid;
    if (must_pop) chk("stream_valid", {31'b0, pv}, 32'd1);
    if (pv && ordy) begin
      chk("stream_order", out_inst, 32'h0080_006F | (32'(pop_id) << 7));
      pop_id++;
    end
    tick();
    if (iv && rdy) next_id++;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_kind = '0;
    in_offset = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
    in_funct3 = '0; out_ready = 1'b1;
    #3;
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_inst", out_inst, 32'd0);
    chk("rst_out_err", {31'b0, out_err}, 32'd0);
    chk("rst_enc_cnt", {16'b0, enc_count}, 32'd0);
    chk("rst_err_cnt", {16'b0, err_count}, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    tick();

    push_one(2'd0, 32'hFFFF_FFFC, 5'd0, 5'd1, 5'd2, 3'd0);
    chk("br_latency", {31'b0, out_valid}, 32'd0);
    tick();
    head("br_m4", 32'hFE20_8EE3, 1'b0);

    push_one(2'd0, 32'h0000_0FFE, 5'd0, 5'd0, 5'd0, 3'd0);
    tick();
    head("br_max", 32'h7E00_0FE3, 1'b0);
    push_one(2'd0, 32'h0000_1000, 5'd0, 5'd0, 5'd0, 3'd0);
    tick();
    head("br_ovf", 32'h0000_0013, 1'b1);

    push_one(2'd1, 32'h000F_FFFE, 5'd1, 5'd0, 5'd0, 3'd0);
    tick();
    head("jal_max", 32'h7FFF_F0EF, 1'b0);
    push_one(2'd1, 32'h0010_0000, 5'd1, 5'd0, 5'd0, 3'd0);
    tick();
    head("jal_ovf", 32'h0000_0013, 1'b1);

    push_one(2'd2, 32'hFFFF_F800, 5'd0, 5'd5, 5'd0, 3'd0);
    tick();
    head("jalr_min", 32'h8002_8067, 1'b0);
    push_one(2'd2, 32'h0000_0003, 5'd0, 5'd5, 5'd0, 3'd0);
    tick();
    head("jalr_odd", 32'h0000_0013, 1'b1);
    push_one(2'd3, 32'h0000_0000, 5'd0, 5'd0, 5'd0, 3'd0);
    tick();
    head("kind_ill", 32'h0000_0013, 1'b1);
    tick();
    chk("stat_enc", {16'b0, enc_count}, EXP_OK);
    chk("stat_err", {16'b0, err_count}, EXP_BAD);

    next_id = 0; pop_id = 0;
    repeat (10) cyc(1'b1, 1'b0, 1'b0);
    in_valid = 1'b0;
    #1;
    chk("bp_accepted", next_id, 32'd5);
    chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
    repeat (5) cyc(1'b0, 1'b1, 1'b1);
    chk("bp_drained", pop_id, 32'd5);
    chk("bp_empty", {31'b0, out_valid}, 32'd0);

    next_id = 0; pop_id = 0;
    repeat (10) cyc(1'b1, 1'b0, 1'b0);
    repeat (8) cyc(1'b1, 1'b1, 1'b1);
    chk("wrap_accepts", next_id, 32'd13);
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    chk("wrap_full", {31'b0, in_ready}, 32'd0);
    repeat (10) cyc(1'b0, 1'b1, 1'b0);
    chk("wrap_drained", pop_id, 32'd13);
    chk("wrap_empty", {31'b0, out_valid}, 32'd0);

    next_id = 20; pop_id = 20;
    repeat (3) cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("fl_before", {31'b0, out_valid}, 32'd1);
    flush = 1'b1; in_valid = 1'b1; in_rd = 5'd9; out_ready = 1'b1;
    #1;
    chk("fl_in_ready", {31'b0, in_ready}, 32'd0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_cleared", {31'b0, out_valid}, 32'd0);
    tick();
    chk("fl_no_accept", {31'b0, out_valid}, 32'd0);

    repeat (3) cyc(1'b1, 1'b0, 1'b0);
    chk("rs_before", {31'b0, out_valid}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("rs_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rs_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rs_out_inst", out_inst, 32'd0);
    chk("rs_out_err", {31'b0, out_err}, 32'd0);
    chk("rs_enc_cnt", {16'b0, enc_count}, 32'd0);
    #1 reset = 1'b0;
    in_valid = 1'b0;
    tick();

`ifdef ENC_STATS_EN
    out_ready = 1'b1; in_kind = 2'd3; in_valid = 1'b1;
    repeat (65540) @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) tick();
    chk("sat_err", {16'b0, err_count}, 32'h0000_FFFF);
    chk("sat_enc", {16'b0, enc_count}, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
